// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared widths, state encoding and wait limit for the MEM-stage controller
package mips_mem_pkg;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage load/store initiator for the single-port data memory
// One access = accept cycle + WAIT_CYCLES strobe cycles + one strobe-low DONE cycle.
module mem_stage_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = mips_mem_pkg::ADDR_W,
  parameter int DATA_W      = mips_mem_pkg::DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] WriteData_dmem,
  input  logic [DATA_W-1:0] ReadData_dmem
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_DONE   = DONE;

  // Out-of-range settings are clamped so the 4-bit counter can never wrap.
  localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 :
                            (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_EFF - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_op;
  logic              r_mem_write;
  logic              r_mem_read;
  logic              r_load_valid;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_load_data;
  logic              w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_op         <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_load_valid <= 1'b0;
      r_address    <= '0;
      r_wdata      <= '0;
      r_load_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_address   <= req_addr;
            r_wdata     <= req_wdata;
            r_op        <= req_write;
            r_cnt       <= CNT_INIT;
            r_mem_write <= req_write;
            r_mem_read  <= !req_write;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            if (!r_op) begin
              r_load_data  <= ReadData_dmem;
              r_load_valid <= 1'b1;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_load_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_mem_write  <= 1'b0;
          r_mem_read   <= 1'b0;
          r_load_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  // DONE releases the pipeline; the held request there is the one just completed.
  always_comb begin
    w_stall = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_IDLE:   w_stall = req_valid;
        ST_ACCESS: w_stall = 1'b1;
        default:   w_stall = 1'b0;
      endcase
    end
  end

  assign stall          = w_stall;
  assign load_valid     = r_load_valid;
  assign load_data      = r_load_data;
  assign MemWrite       = r_mem_write;
  assign MemRead        = r_mem_read;
  assign address        = r_address;
  assign WriteData_dmem = r_wdata;

  a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n) !(r_mem_write && r_mem_read));

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - bench for mem_stage_ctrl with WAIT_CYCLES=1 and WAIT_CYCLES=3 instances
module tb_mem_stage_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]       req_valid;
  logic [1:0]       req_write;
  logic [1:0][7:0]  req_addr;
  logic [1:0][15:0] req_wdata;
  logic [1:0]       stall;
  logic [1:0]       load_valid;
  logic [1:0][15:0] load_data;
  logic [1:0]       mem_write;
  logic [1:0]       mem_read;
  logic [1:0][7:0]  address;
  logic [1:0][15:0] wdata_dmem;
  logic [15:0]      rd0;
  logic [15:0]      rd1;

  logic [15:0]  mem0 [256];
  logic [15:0]  mem1 [256];
  logic [255:0] wr_mask0 = '0;
  logic [255:0] wr_mask1 = '0;

  logic [15:0] ref_mem   [2][256];
  bit          ref_known [2][256];
  logic [15:0] last_load [2];
  int          wait_of   [2];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stage_ctrl #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .stall(stall[0]), .load_valid(load_valid[0]), .load_data(load_data[0]),
    .MemWrite(mem_write[0]), .MemRead(mem_read[0]), .address(address[0]),
    .WriteData_dmem(wdata_dmem[0]), .ReadData_dmem(rd0)
  );

  mem_stage_ctrl #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .stall(stall[1]), .load_valid(load_valid[1]), .load_data(load_data[1]),
    .MemWrite(mem_write[1]), .MemRead(mem_read[1]), .address(address[1]),
    .WriteData_dmem(wdata_dmem[1]), .ReadData_dmem(rd1)
  );

  // Data memories: unwritten words read back as their own address (mem[i] = i).
  always @(posedge clk) begin
    if (mem_write[0]) begin
      mem0[address[0]]     <= wdata_dmem[0];
      wr_mask0[address[0]] <= 1'b1;
    end
    if (mem_write[1]) begin
      mem1[address[1]]     <= wdata_dmem[1];
      wr_mask1[address[1]] <= 1'b1;
    end
  end
  assign rd0 = wr_mask0[address[0]] ? mem0[address[0]] : {8'h00, address[0]};
  assign rd1 = wr_mask1[address[1]] ? mem1[address[1]] : {8'h00, address[1]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_memwrite"}, mem_write[d], 0);
      chk({tag, "_memread"}, mem_read[d], 0);
      chk({tag, "_load_valid"}, load_valid[d], 0);
      chk({tag, "_stall"}, stall[d], 0);
      chk({tag, "_address"}, address[d], 0);
      chk({tag, "_wdata"}, wdata_dmem[d], 0);
      chk({tag, "_load_data"}, load_data[d], 0);
    end
  endtask

  // One request from the accept cycle through DONE; expectations come from the timing rules.
  task automatic access(input int d, input logic wr, input logic [7:0] a,
                        input logic [15:0] wd, output int lv_cyc);
    int n_stall = 0, n_rd = 0, n_wr = 0, n_both = 0, n_bad = 0, n_lv = 0;
    int w = wait_of[d];
    logic done = 1'b0;
    logic gap_ok = 1'b0;
    logic [15:0] lv_val = '0;
    lv_cyc = -1;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (stall[d]) n_stall++;
      if (mem_read[d]) n_rd++;
      if (mem_write[d]) n_wr++;
      if (mem_read[d] && mem_write[d]) n_both++;
      if ((mem_read[d] || mem_write[d]) && (address[d] !== a || wdata_dmem[d] !== wd)) n_bad++;
      if (load_valid[d]) begin
        n_lv++;
        lv_val = load_data[d];
        lv_cyc = cyc;
      end
      if (!stall[d]) begin
        done   = 1'b1;
        gap_ok = !mem_read[d] && !mem_write[d];
      end else if (n > 0) begin
        req_write[d] = 1'($urandom_range(0, 1));
        req_addr[d]  = 8'($urandom);
        req_wdata[d] = 16'($urandom);
      end
    end
    chk("done_reached", done, 1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    chk("load_valid_single", load_valid[d], 0);
    chk("stall_cycles", n_stall, w + 1);
    chk("read_strobe_cycles", n_rd, wr ? 0 : w);
    chk("write_strobe_cycles", n_wr, wr ? w : 0);
    chk("both_strobes", n_both, 0);
    chk("addr_data_stable", n_bad, 0);
    chk("done_gap_strobes_low", gap_ok, 1);
    chk("address_out", address[d], a);
    chk("load_valid_count", n_lv, wr ? 0 : 1);
    if (wr) begin
      chk("load_data_hold", load_data[d], last_load[d]);
      ref_mem[d][a]   = wd;
      ref_known[d][a] = 1'b1;
    end else begin
      if (ref_known[d][a]) begin
        chk("load_data_value", lv_val, ref_mem[d][a]);
        chk("load_data_out", load_data[d], ref_mem[d][a]);
        last_load[d] = ref_mem[d][a];
      end else begin
        last_load[d] = load_data[d];
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, lc;
    logic       wr;
    logic [7:0] a;

    wait_of[0] = 1;
    wait_of[1] = 3;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) begin
        ref_mem[d][i]   = 16'(i);
        ref_known[d][i] = 1'b1;
      end
      last_load[d] = '0;
    end
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;

    rst_n = 1'b0;
    #13;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    access(0, 1'b0, 8'h05, 16'h0000, lc);
    access(0, 1'b1, 8'h10, 16'h1234, lc);
    access(0, 1'b0, 8'h10, 16'h0000, lc);
    access(1, 1'b0, 8'hFF, 16'h0000, lc);

    access(0, 1'b0, 8'h01, 16'h0000, c1);
    access(0, 1'b0, 8'h02, 16'h0000, c2);
    chk("b2b_load_valid_spacing", c2 - c1, 3);
    chk("b2b_second_data", load_data[0], 16'h0002);

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 25; k++) begin
        wr = 1'($urandom_range(0, 1));
        a  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
        access(d, wr, a, 16'($urandom), lc);
      end
    end

    // Abort a store mid-strobe with an asynchronous reset.
    @(posedge clk);
    #1;
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 8'h20;
    req_wdata[1] = 16'hBEEF;
    @(posedge clk);
    #1;
    chk("abort_memwrite_before", mem_write[1], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    #1;
    rst_n = 1'b1;
    #1;
    chk("abort_stall_follows_req", stall[1], 1);
    chk("abort_no_load_valid", load_valid[1], 0);
    chk("abort_no_memwrite", mem_write[1], 0);
    req_valid[1] = 1'b0;
    #1;
    chk("abort_stall_idle", stall[1], 0);
    ref_known[1][8'h20] = 1'b0;
    last_load[0] = '0;
    last_load[1] = '0;
    @(posedge clk);
    #1;

    access(1, 1'b1, 8'h21, 16'hA5A5, lc);
    access(1, 1'b0, 8'h21, 16'h0000, lc);
    access(0, 1'b0, 8'h10, 16'h0000, lc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage initiator for the 16-bit single-port data memory in the pipelined MIPS.
- Accepts one load/store request from the EX/MEM pipeline register and drives the memory port: MemWrite, MemRead, address, WriteData_dmem.
- Holds address and data stable for a programmable number of strobe cycles, guarantees a dead turnaround cycle between accesses, registers load data, and stalls the pipeline while an access is in flight.

Parameters:
- ADDR_W, 8, data memory address width (256 words).
- DATA_W, 16, data word width.
- WAIT_CYCLES, 1, cycles the read/write strobe is held per access; legal range 1..15.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  EX/MEM holds a memory instruction.
- req_write  in  1  1 = store, 0 = load; sampled with req_valid.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- stall  out  1  freeze PC/IF/ID/EX/MEM registers.
- load_valid  out  1  one-cycle pulse: load_data updated.
- load_data  out  DATA_W  last completed load result.
- MemWrite  out  1  write strobe to data memory.
- MemRead  out  1  read strobe to data memory.
- address  out  ADDR_W  memory address.
- WriteData_dmem  out  DATA_W  memory write data.
- ReadData_dmem  in  DATA_W  memory read data; combinational, valid while MemRead is high.

Behaviour:
- Reset: async, active-low.
  - State goes to IDLE and the counter to 0.
  - MemWrite, MemRead, load_valid and stall are 0.
  - address, WriteData_dmem and load_data are 0.
  - Strobes must drop immediately on assertion, not at the next edge.
- States: IDLE, ACCESS, DONE. All outputs except stall are registered.
- IDLE:
  - Strobes are 0.
  - stall = req_valid (combinational).
  - On a rising edge with req_valid=1: latch req_addr into address, req_wdata into WriteData_dmem (loads too) and req_write into an internal op flag; set cnt = WAIT_CYCLES-1; go to ACCESS.
- ACCESS:
  - Exactly one strobe is high: MemWrite = op, MemRead = !op. Both high together is illegal; assert in sim.
  - address and WriteData_dmem are held constant. stall=1. req_* inputs are ignored.
  - Each edge with cnt!=0: cnt decrements.
  - Edge with cnt==0: for a load, register ReadData_dmem into load_data; go to DONE.
- DONE:
  - Both strobes 0; stall=0, so the pipeline advances on this edge.
  - load_valid=1 only if op was a load.
  - req_valid is ignored because it still carries the completed instruction.
  - Next edge goes to IDLE unconditionally.
- Timing: strobe width is exactly WAIT_CYCLES. An access occupies 1 accept cycle + WAIT_CYCLES + 1 DONE cycle; with WAIT_CYCLES=1 that is 3 cycles.
- load_data holds its value across stores and idle time; it changes only on a completed load.
- Back-to-back requests always have at least one strobe-low cycle (DONE) between strobes, so a combinational memory never sees an address change under an active strobe.
- Address range is 0..255 with no wrap logic; the address is passed through unchanged.
- Reset during ACCESS aborts the access. A store may be partially committed; software must not depend on it.

Decomposition:
- Shared package mips_mem_pkg holds ADDR_W, DATA_W, the state enum {IDLE, ACCESS, DONE} and the MAX_WAIT=15 constant.
- No sub-module; the 4-bit wait counter stays inline.

Test Plan:
- Reset with rst_n=0 mid-sim at a non-edge time -> all outputs 0 within the same timestep; state IDLE.
- WAIT=1, memory preloaded with mem[i]=i, load addr 0x05 -> MemRead high exactly 1 cycle with address=0x05; load_data=0x0005; one load_valid pulse; stall high 2 cycles.
- Store 0x1234 to 0x10, then load 0x10 -> MemWrite high 1 cycle with WriteData_dmem=0x1234; load_data=0x1234; one strobe-low cycle between accesses; MemRead and MemWrite never both high.
- WAIT_CYCLES=3, load 0xFF -> MemRead high 3 consecutive cycles with address stable at 0xFF; load_data=0x00FF; stall high 4 cycles.
- Loads 0x01 then 0x02 back-to-back, with req_valid held and the pipeline advancing on stall=0 -> load_valid pulses exactly 3 cycles apart; load_data 0x0001 then 0x0002.
- rst_n dropped during the ACCESS of a store to 0x20 -> MemWrite falls asynchronously; no load_valid; after release, state IDLE and stall=req_valid.
